piezo_melody_seq: RTL and testbench

PIEZO_MELODY_SEQ -- requirements
Module: piezo_melody_seq

---
 rtl/piezo_melody_seq.sv | 157 +++++++++++++++
 tb/tb_piezo_melody_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/piezo_melody_seq.sv
// Melody sequencer for a piezo tone generator: plays a fixed 16-entry note ROM
// with a silent gap after each note, and passes the manual key bank through when idle.
module piezo_melody_seq #(
    parameter int TICK_DIV = 2500000,
    parameter int GAP_CYC  = 250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [11:0] sw2,
    output logic [11:0] note_sel,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    // start and stop are plain levels sampled every clk edge, with no handshake:
    // start is acted on only in IDLE, stop wins over start, and done is a 1-cycle strobe.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int CNT_MAX = (8 * TICK_DIV > GAP_CYC) ? 8 * TICK_DIV : GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    ptr;
    logic [1:0]    dur;

    logic [5:0]    first_entry;
    logic [5:0]    nxt_entry;
    logic [3:0]    nxt_ptr;
    logic [CW-1:0] note_last;
    logic [CW-1:0] gap_last;
    int            note_len;

    function automatic logic [5:0] rom(input logic [3:0] addr);
        logic [5:0] entry;
        case (addr)
            4'd0:    entry = {4'd1, 2'd0};
            4'd1:    entry = {4'd2, 2'd0};
            4'd2:    entry = {4'd3, 2'd0};
            4'd3:    entry = {4'd4, 2'd0};
            4'd4:    entry = {4'd5, 2'd0};
            4'd5:    entry = {4'd6, 2'd0};
            4'd6:    entry = {4'd7, 2'd0};
            4'd7:    entry = {4'd8, 2'd0};
            default: entry = {4'd15, 2'd0};
        endcase
        return entry;
    endfunction

    // idx 0 and 12..14 are rests; 15 never reaches the decoder as a note
    function automatic logic [11:0] decode(input logic [3:0] idx);
        logic [11:0] code;
        code = 12'd0;
        if (idx >= 4'd1 && idx <= 4'd11) begin
            code = 12'd1 << idx;
        end
        return code;
    endfunction

    always_comb begin
        first_entry = rom(4'd0);
        nxt_ptr     = ptr + 4'd1;
        nxt_entry   = rom(nxt_ptr);
        note_len    = TICK_DIV << dur;
        note_last   = CW'(note_len - 1);
        gap_last    = CW'(GAP_CYC - 1);
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= 4'd0;
            dur      <= 2'd0;
            note_sel <= 12'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    note_sel <= sw2;
                    cnt      <= '0;
                    ptr      <= 4'd0;
                    if (start && !stop) begin
                        if (first_entry[5:2] == 4'd15) begin
                            done <= 1'b1;
                        end else begin
                            state    <= NOTE;
                            busy     <= 1'b1;
                            note_sel <= decode(first_entry[5:2]);
                            dur      <= first_entry[1:0];
                        end
                    end
                end
                NOTE: begin
                    if (stop) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        ptr      <= 4'd0;
                        cnt      <= '0;
                        note_sel <= sw2;
                    end else if (cnt == note_last) begin
                        state    <= GAP;
                        cnt      <= '0;
                        note_sel <= 12'd0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    note_sel <= 12'd0;
                    if (stop) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        ptr      <= 4'd0;
                        cnt      <= '0;
                        note_sel <= sw2;
                    end else if (cnt == gap_last) begin
                        cnt <= '0;
                        if (ptr == 4'd15 || nxt_entry[5:2] == 4'd15) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            ptr      <= 4'd0;
                            note_sel <= sw2;
                        end else begin
                            state    <= NOTE;
                            ptr      <= nxt_ptr;
                            dur      <= nxt_entry[1:0];
                            note_sel <= decode(nxt_entry[5:2]);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ptr      <= 4'd0;
                    cnt      <= '0;
                    note_sel <= 12'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piezo_melody_seq.sv
// Directed bench for piezo_melody_seq with TICK_DIV=4, GAP_CYC=2: each melody note
// is 4 cycles of tone plus 2 of silence, eight notes, then done.
module tb_piezo_melody_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [11:0] sw2;
    logic [11:0] note_sel;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int vectors;
    int miscompares;

    piezo_melody_seq #(.TICK_DIV(4), .GAP_CYC(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .sw2       (sw2),
        .note_sel  (note_sel),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // outputs are sampled and inputs changed 1 time unit after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // expected outputs at playback cycle c (1..48): 6 cycles per entry, tone for the first 4
    task automatic expect_play(input int c);
        int k;
        int p;
        logic [11:0] exp_note;
        k = (c - 1) / 6;
        p = (c - 1) % 6;
        exp_note = (p < 4) ? (12'd1 << (k + 1)) : 12'd0;
        check("play_note", note_sel, exp_note);
        check("play_busy", 12'(busy), 12'd1);
        check("play_done", 12'(done), 12'd0);
        check("play_state", 12'(dbg_state), (p < 4) ? 12'd1 : 12'd2);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        sw2   = 12'h008;

        // reset held for three cycles, then released
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_note", note_sel, 12'h000);
            check("rst_busy", 12'(busy), 12'd0);
            check("rst_done", 12'(done), 12'd0);
        end
        reset = 1'b1;
        step();
        check("idle_passthru", note_sel, 12'h008);
        check("idle_busy", 12'(busy), 12'd0);
        check("idle_state", 12'(dbg_state), 12'd0);

        // full melody with sw2 toggling underneath; cycle 0 is the start cycle
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 48; c++) begin
            expect_play(c);
            sw2 = (c == 48 || (c % 2) == 1) ? 12'h800 : 12'h000;
            step();
        end
        check("end_done", 12'(done), 12'd1);
        check("end_busy", 12'(busy), 12'd0);
        check("end_note", note_sel, 12'h800);
        check("end_state", 12'(dbg_state), 12'd0);
        sw2 = 12'h010;
        step();
        check("post_done", 12'(done), 12'd0);
        check("post_note", note_sel, 12'h010);

        // stop during the second note
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            expect_play(c);
            if (c < 9) step();
        end
        stop = 1'b1;
        sw2  = 12'h020;
        step();
        stop = 1'b0;
        check("stop_busy", 12'(busy), 12'd0);
        check("stop_note", note_sel, 12'h020);
        check("stop_done", 12'(done), 12'd0);
        check("stop_state", 12'(dbg_state), 12'd0);
        step();
        check("stop_done2", 12'(done), 12'd0);
        check("stop_busy2", 12'(busy), 12'd0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        step();
        check("both_busy", 12'(busy), 12'd0);
        check("both_done", 12'(done), 12'd0);
        check("both_state", 12'(dbg_state), 12'd0);
        start = 1'b0;
        stop  = 1'b0;
        step();
        check("both_done2", 12'(done), 12'd0);

        // reset in the middle of playback, then replay from entry 0
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            expect_play(c);
            if (c < 20) step();
        end
        reset = 1'b0;
        start = 1'b1;
        step();
        check("midrst_note", note_sel, 12'h000);
        check("midrst_busy", 12'(busy), 12'd0);
        check("midrst_state", 12'(dbg_state), 12'd0);
        reset = 1'b1;
        start = 1'b0;
        sw2   = 12'h000;
        step();
        check("rel_busy", 12'(busy), 12'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("replay_note", note_sel, 12'h002);
        check("replay_busy", 12'(busy), 12'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("replay_stop", 12'(busy), 12'd0);

        // start held high: ignored while busy, restarts right after done
        start = 1'b1;
        step();
        for (int c = 1; c <= 48; c++) begin
            expect_play(c);
            step();
        end
        check("hold_done", 12'(done), 12'd1);
        check("hold_busy", 12'(busy), 12'd0);
        step();
        check("hold_restart_note", note_sel, 12'h002);
        check("hold_restart_busy", 12'(busy), 12'd1);
        check("hold_restart_done", 12'(done), 12'd0);
        start = 1'b0;
        stop  = 1'b1;
        step();
        stop = 1'b0;
        check("hold_stop_busy", 12'(busy), 12'd0);
        check("hold_stop_done", 12'(done), 12'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
